nibble_gen: RTL and testbench
=============================

NIBBLE_GEN -- requirements
Module: nibble_gen

Interface
REQ-001 Parameter DIV, default 4, update period in clock cycles; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 sreset_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 start  input  1  level; in IDLE, moves the block to RUN.
REQ-005 stop  input  1  level; returns the block to IDLE from RUN or HOLD.
REQ-006 pause  input  1  level; RUN->HOLD while high, HOLD->RUN when low.
REQ-007 mode  input  2  update rule: 00 up, 01 down, 10 load, 11 lfsr.
REQ-008 load_val  input  4  value taken in load mode.
REQ-009 Y  output  4  registered nibble, feeds the downstream 4-bit D register.
REQ-010 upd  output  1  one-cycle pulse, high in the cycle after Y changes by a tick.
REQ-011 wrap  output  1  one-cycle pulse, high with upd when up/down rolls over.
REQ-012 busy  output  1  high in RUN and HOLD, low in IDLE.

Function
REQ-013 FSM states IDLE, RUN, HOLD; all outputs registered, no combinational path from inputs to outputs.
REQ-014 IDLE: start=1 and stop=0 -> RUN; otherwise stay in IDLE.
REQ-015 RUN: stop=1 -> IDLE; else pause=1 -> HOLD; else stay in RUN.
REQ-016 HOLD: stop=1 -> IDLE; else pause=0 -> RUN; else stay in HOLD.
REQ-017 Priority: stop over pause over start when asserted together.
REQ-018 Prescaler pcnt (8 bit) cleared to 0 on IDLE->RUN; increments each RUN cycle, wraps DIV-1->0.
REQ-019 Tick = state RUN and pcnt==DIV-1 and stop=0 and pause=0; Y updates on that edge.
REQ-020 First Y update occurs on the DIV-th rising edge after the edge that samples start; then every DIV edges.
REQ-021 DIV=1: tick every RUN cycle.
REQ-022 HOLD freezes pcnt and Y; resuming continues from the frozen pcnt.
REQ-023 mode sampled only at tick; mode changes between ticks have no effect.
REQ-024 Up: Y<=Y+1 mod 16; 15->0 pulses wrap.
REQ-025 Down: Y<=Y-1 mod 16; 0->15 pulses wrap.
REQ-026 Load: Y<=load_val; wrap stays 0.
REQ-027 upd pulses after every tick, even if the new Y equals the old Y.
REQ-028 IDLE and stop hold Y at its last value; they do not clear Y.

Reset
REQ-029 sreset_n=0 at a rising edge: state IDLE, Y=0000, pcnt=0, upd=0, wrap=0, busy=0.
REQ-030 Reset overrides every other input, including while in RUN or HOLD.
REQ-031 With sreset_n low and no clock edge, no output changes.

Configuration
REQ-032 Macro NIBBLE_GEN_LFSR_EN selects LFSR mode.
REQ-033 Defined: mode 11 updates Y as a 4-bit Fibonacci LFSR (x^4+x^3+1), Y<={Y[2:0],Y[3]^Y[2]}.
REQ-034 Defined: a tick with Y=0000 in mode 11 loads 0001; the full sequence period is 15.
REQ-035 Not defined: mode 11 leaves Y unchanged; upd still pulses and wrap stays 0.

Verification
REQ-036 Reset, start=1, mode=00, DIV=4 -> Y=1 at 4th edge after start; upd pulses; busy=1.
REQ-037 Up count from Y=14, DIV=1 -> Y=15 then 0; wrap=1 only with the 15->0 upd.
REQ-038 Y=3, pause held 10 cycles mid-period -> Y, pcnt frozen; update resumes after the remaining cycles.
REQ-039 start=stop=pause=1 in IDLE -> stays IDLE; in RUN -> IDLE, Y held.
REQ-040 mode=10, load_val=1010 -> Y=1010 at tick; mode switched to 01 between ticks -> next tick Y=1001.
REQ-041 sreset_n=0 mid-RUN at Y=7 -> next edge Y=0000, IDLE; mode=11 with the macro defined from Y=0 -> 0001, 0010, 0100, 1001 and period 15.

Source files
------------

// File: rtl/nibble_gen.sv
// ============================================================================
// Module   : nibble_gen
// Purpose  : Prescaled 4-bit nibble generator (up/down/load/LFSR) with an
//            IDLE/RUN/HOLD controller; all outputs registered.
// Options  : NIBBLE_GEN_LFSR_EN enables the LFSR rule for mode 2'b11.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       sreset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [1:0] mode,
  input  logic [3:0] load_val,
  output logic [3:0] Y,
  output logic       upd,
  output logic       wrap,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_LOAD = 2'b10;
  localparam logic [1:0] MODE_LFSR = 2'b11;

  localparam logic [7:0] PCNT_LAST = 8'(DIV - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] pcnt_q,  pcnt_d;
  logic [3:0] y_q,     y_d;
  logic       upd_q,   upd_d;
  logic       wrap_q,  wrap_d;
  logic       busy_q,  busy_d;
  logic       tick;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!sreset_n) begin
      state_q <= ST_IDLE;
      pcnt_q  <= 8'd0;
      y_q     <= 4'd0;
      upd_q   <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      y_q     <= y_d;
      upd_q   <= upd_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; stop dominates pause, which dominates start
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && !stop) state_d = ST_RUN;
      ST_RUN: begin
        if (stop)       state_d = ST_IDLE;
        else if (pause) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (stop)        state_d = ST_IDLE;
        else if (!pause) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tick = (state_q == ST_RUN) && (pcnt_q == PCNT_LAST) && !stop && !pause;

  // Prescaler and nibble update; pcnt only advances on cycles that stay in RUN
  always_comb begin
    pcnt_d = pcnt_q;
    y_d    = y_q;
    wrap_d = 1'b0;
    upd_d  = tick;
    busy_d = (state_d != ST_IDLE);

    if ((state_q == ST_IDLE) && (state_d == ST_RUN)) begin
      pcnt_d = 8'd0;
    end else if ((state_q == ST_RUN) && !stop && !pause) begin
      pcnt_d = (pcnt_q == PCNT_LAST) ? 8'd0 : pcnt_q + 8'd1;
    end

    if (tick) begin
      case (mode)
        MODE_UP: begin
          y_d    = y_q + 4'd1;
          wrap_d = (y_q == 4'hF);
        end
        MODE_DOWN: begin
          y_d    = y_q - 4'd1;
          wrap_d = (y_q == 4'h0);
        end
        MODE_LOAD: y_d = load_val;
        MODE_LFSR: begin
`ifdef NIBBLE_GEN_LFSR_EN
          // All-zero is the LFSR lock-up state, so it is forced back into the sequence
          y_d = (y_q == 4'h0) ? 4'h1 : {y_q[2:0], y_q[3] ^ y_q[2]};
`else
          y_d = y_q;
`endif
        end
        default: y_d = y_q;
      endcase
    end
  end

  assign Y    = y_q;
  assign upd  = upd_q;
  assign wrap = wrap_q;
  assign busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_gen.sv
// ============================================================================
// Module   : tb_nibble_gen
// Purpose  : Scoreboard bench for nibble_gen (DIV=4 main instance plus a
//            DIV=1 instance); LFSR expectations follow NIBBLE_GEN_LFSR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_gen;

  logic       clk = 1'b0;
  logic       sreset_n = 1'b0;
  logic       rst1_n = 1'b0;
  logic       start = 1'b0;
  logic       start1 = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] load_val = 4'h0;
  logic [3:0] Y, Y1;
  logic       upd, wrap, busy, upd1, wrap1, busy1;

  int         checks = 0;
  int         errors = 0;
  logic       mon_en = 1'b0;
  logic [4:0] sb[$];
  logic [3:0] y_m = 4'h0;

  nibble_gen #(.DIV(4)) u_dut (
    .clk(clk), .sreset_n(sreset_n), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .load_val(load_val), .Y(Y), .upd(upd), .wrap(wrap), .busy(busy)
  );

  nibble_gen #(.DIV(1)) u_dut1 (
    .clk(clk), .sreset_n(rst1_n), .start(start1), .stop(stop), .pause(pause),
    .mode(mode), .load_val(load_val), .Y(Y1), .upd(upd1), .wrap(wrap1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // Every upd pulse of the main instance consumes one expected {wrap,Y}
  always @(negedge clk) begin
    logic [4:0] exp_v;
    if (mon_en && (upd === 1'b1)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_upd: got Y=%h wrap=%b, required no upd", Y, wrap);
      end else begin
        exp_v = sb.pop_front();
        if ({wrap, Y} !== exp_v) begin
          errors++;
          $display("FAIL sb_tick: got wrap=%b Y=%h, required wrap=%b Y=%h",
                   wrap, Y, exp_v[4], exp_v[3:0]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [3:0] m11_next(input logic [3:0] y);
`ifdef NIBBLE_GEN_LFSR_EN
    if (y == 4'h0) return 4'h1;
    return {y[2:0], y[3] ^ y[2]};
`else
    return y;
`endif
  endfunction

  task automatic push(input logic w, input logic [3:0] y);
    y_m = y;
    sb.push_back({w, y});
  endtask

  task automatic test_reset();
    sreset_n = 1'b0;
    step(2);
    checks++; if (Y !== 4'h0) begin errors++; $display("FAIL reset_Y: got %h, required 0", Y); end
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL reset_upd: got %b, required 0", upd); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b, required 0", wrap); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    sreset_n = 1'b1;
    mon_en   = 1'b1;
    step(1);
  endtask

  task automatic test_start();
    mode  = 2'b00;
    start = 1'b1;
    push(1'b0, 4'h1);
    step(1);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b, required 1", busy); end
    step(3);
    checks++; if (Y !== 4'h0) begin errors++; $display("FAIL start_early: got %h, required 0", Y); end
    step(1);
    checks++; if (Y !== 4'h1) begin errors++; $display("FAIL start_first: got %h, required 1", Y); end
    checks++; if (upd !== 1'b1) begin errors++; $display("FAIL start_upd: got %b, required 1", upd); end
    step(1);
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL start_upd_width: got %b, required 0", upd); end
  endtask

  task automatic test_pause();
    push(1'b0, 4'h2);
    push(1'b0, 4'h3);
    step(7);
    checks++; if (Y !== 4'h3) begin errors++; $display("FAIL pause_setup: got %h, required 3", Y); end
    step(2);
    pause = 1'b1;
    step(10);
    checks++; if (Y !== 4'h3) begin errors++; $display("FAIL pause_frozen: got %h, required 3", Y); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pause_busy: got %b, required 1", busy); end
    pause = 1'b0;
    step(2);
    checks++; if (Y !== 4'h3) begin errors++; $display("FAIL pause_resume_early: got %h, required 3", Y); end
    push(1'b0, 4'h4);
    step(1);
    checks++; if (Y !== 4'h4) begin errors++; $display("FAIL pause_resume: got %h, required 4", Y); end
  endtask

  task automatic test_modes();
    mode = 2'b10; load_val = 4'hA;
    push(1'b0, 4'hA);
    step(4);
    checks++; if (Y !== 4'hA) begin errors++; $display("FAIL load: got %h, required a", Y); end
    mode = 2'b00;
    step(2);
    mode = 2'b01;
    push(1'b0, 4'h9);
    step(2);
    checks++; if (Y !== 4'h9) begin errors++; $display("FAIL mode_switch_down: got %h, required 9", Y); end
    mode = 2'b10; load_val = 4'h0;
    push(1'b0, 4'h0);
    step(4);
    mode = 2'b01;
    push(1'b1, 4'hF);
    step(4);
    checks++; if (Y !== 4'hF) begin errors++; $display("FAIL down_wrap: got %h, required f", Y); end
    mode = 2'b11;
    push(1'b0, m11_next(4'hF));
    step(4);
    checks++; if (Y !== y_m) begin errors++; $display("FAIL mode11: got %h, required %h", Y, y_m); end
  endtask

  task automatic test_priority();
    start = 1'b1; stop = 1'b1; pause = 1'b1;
    step(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_run_busy: got %b, required 0", busy); end
    checks++; if (Y !== y_m) begin errors++; $display("FAIL prio_run_Y: got %h, required %h", Y, y_m); end
    step(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_idle_busy: got %b, required 0", busy); end
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    step(2);
    checks++; if (Y !== y_m) begin errors++; $display("FAIL idle_hold_Y: got %h, required %h", Y, y_m); end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; mode = 2'b10; load_val = 4'h7;
    push(1'b0, 4'h7);
    step(1);
    start = 1'b0;
    step(4);
    checks++; if (Y !== 4'h7) begin errors++; $display("FAIL rst_setup: got %h, required 7", Y); end
    mode = 2'b00;
    step(2);
    sreset_n = 1'b0;
    start    = 1'b1;
    step(1);
    checks++; if (Y !== 4'h0) begin errors++; $display("FAIL rst_mid_Y: got %h, required 0", Y); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b, required 0", busy); end
    step(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_override: got %b, required 0", busy); end
    sreset_n = 1'b1;
    push(1'b0, 4'h1);
    step(1);
    start = 1'b0;
    step(3);
    checks++; if (Y !== 4'h0) begin errors++; $display("FAIL rst_restart_early: got %h, required 0", Y); end
    step(1);
    checks++; if (Y !== 4'h1) begin errors++; $display("FAIL rst_restart: got %h, required 1", Y); end
  endtask

  task automatic test_lfsr();
    sreset_n = 1'b0;
    step(1);
    sreset_n = 1'b1;
    y_m = 4'h0;
    mode = 2'b11; start = 1'b1;
    step(1);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push(1'b0, m11_next(y_m));
      step(4);
      checks++;
      if (Y !== y_m) begin errors++; $display("FAIL lfsr_step%0d: got %h, required %h", i, Y, y_m); end
    end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic test_div1();
    logic [3:0] exp_y [4];
    logic       exp_w [4];
    exp_y[0] = 4'hE; exp_y[1] = 4'hF; exp_y[2] = 4'h0; exp_y[3] = 4'h1;
    exp_w[0] = 1'b0; exp_w[1] = 1'b0; exp_w[2] = 1'b1; exp_w[3] = 1'b0;
    rst1_n = 1'b1;
    step(1);
    mode = 2'b10; load_val = 4'hE; start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL div1_busy: got %b, required 1", busy1); end
    for (int i = 0; i < 4; i++) begin
      step(1);
      mode = 2'b00;
      checks++;
      if ({upd1, wrap1, Y1} !== {1'b1, exp_w[i], exp_y[i]}) begin
        errors++;
        $display("FAIL div1_tick%0d: got upd=%b wrap=%b Y=%h, required upd=1 wrap=%b Y=%h",
                 i, upd1, wrap1, Y1, exp_w[i], exp_y[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_pause();
    test_modes();
    test_priority();
    test_reset_mid_run();
    test_lfsr();
    test_div1();
    step(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending entries, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
